// File: rtl/instr_imm_encoder_pkg.sv
// Shared types and field geometry for the RV32 immediate encoder / instruction-memory writer.
package instr_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2,
        IMM_U = 2'd3
    } imm_type_t;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } enc_state_t;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_W   = 7;
    localparam int REG_W      = 5;
    localparam int FUNCT3_W   = 3;

    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;

endpackage

// File: rtl/instr_imm_encoder_pack.sv
// Combinational RV32 I/S/B/U word packer with immediate range qualification.
// IMM_RANGE_CHECK_EN: when defined, o_range_ok reflects whether imm fits the field; otherwise it is always 1.
module instr_imm_pack
    import instr_pkg::*;
#(
    parameter int address_width = 32
) (
    input  imm_type_t                i_imm_type,
    input  logic [OPCODE_W-1:0]      i_opcode,
    input  logic [REG_W-1:0]         i_rd,
    input  logic [FUNCT3_W-1:0]      i_funct3,
    input  logic [REG_W-1:0]         i_rs1,
    input  logic [REG_W-1:0]         i_rs2,
    input  logic [address_width-1:0] i_imm,
    output logic [address_width-1:0] o_word,
    output logic                     o_range_ok
);

    logic [INSTR_W-1:0] w_imm;
    logic [INSTR_W-1:0] w_word;

    assign w_imm  = INSTR_W'(i_imm);
    assign o_word = address_width'(w_word);

    always_comb begin
        w_word = '0;
        case (i_imm_type)
            IMM_I: w_word = {w_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            IMM_S: w_word = {w_imm[11:5], i_rs2, i_rs1, i_funct3, w_imm[4:0], i_opcode};
            IMM_B: w_word = {w_imm[12], w_imm[10:5], i_rs2, i_rs1, i_funct3,
                             w_imm[4:1], w_imm[11], i_opcode};
            IMM_U: w_word = {w_imm[31:12], i_rd, i_opcode};
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic signed [INSTR_W-1:0] w_simm;
    assign w_simm = signed'(w_imm);

    // Immediate must survive a sign-extending decode of its field unchanged.
    always_comb begin
        o_range_ok = 1'b0;
        case (i_imm_type)
            IMM_I, IMM_S: o_range_ok = (w_simm >= -32'sd2048) && (w_simm <= 32'sd2047);
            IMM_B:        o_range_ok = (w_simm >= -32'sd4096) && (w_simm <= 32'sd4094) && !w_imm[0];
            IMM_U:        o_range_ok = (w_imm[11:0] == 12'd0);
        endcase
    end
`else
    assign o_range_ok = 1'b1;
`endif

endmodule

// File: rtl/instr_imm_encoder.sv
// Sequential instruction-memory writer: accepts field requests, encodes them and writes one word per cycle.
// IMM_RANGE_CHECK_EN: when defined, out-of-range immediates are dropped and raise a sticky o_err.
module instr_imm_encoder
    import instr_pkg::*;
#(
    parameter int                       address_width = 32,
    parameter int                       mem_depth     = 64,
    parameter logic [address_width-1:0] base_addr     = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_clear,
    input  logic                             i_in_valid,
    output logic                             o_in_ready,
    input  imm_type_t                        i_imm_type,
    input  logic [OPCODE_W-1:0]              i_opcode,
    input  logic [REG_W-1:0]                 i_rd,
    input  logic [FUNCT3_W-1:0]              i_funct3,
    input  logic [REG_W-1:0]                 i_rs1,
    input  logic [REG_W-1:0]                 i_rs2,
    input  logic [address_width-1:0]         i_imm,
    output logic                             o_mem_we,
    output logic [address_width-1:0]         o_mem_addr,
    output logic [address_width-1:0]         o_mem_wdata,
    output logic [$clog2(mem_depth+1)-1:0]   o_count,
    output logic                             o_full,
    output logic                             o_err
);

    localparam int CNT_W = $clog2(mem_depth + 1);

    enc_state_t               r_state;
    enc_state_t               w_state_nxt;
    logic                     r_we;
    logic [address_width-1:0] r_addr;
    logic [address_width-1:0] r_wdata;
    logic [CNT_W-1:0]         r_count;
    logic [address_width-1:0] w_word;
    logic                     w_range_ok;
    logic                     w_accept;
    logic                     w_commit;

    instr_imm_pack #(
        .address_width (address_width)
    ) u_pack (
        .i_imm_type (i_imm_type),
        .i_opcode   (i_opcode),
        .i_rd       (i_rd),
        .i_funct3   (i_funct3),
        .i_rs1      (i_rs1),
        .i_rs2      (i_rs2),
        .i_imm      (i_imm),
        .o_word     (w_word),
        .o_range_ok (w_range_ok)
    );

    assign o_in_ready = (r_state == ST_LOAD) && !i_clear;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_commit   = w_accept && w_range_ok;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: if (w_commit && (r_count == CNT_W'(mem_depth - 1))) w_state_nxt = ST_FULL;
            ST_FULL: w_state_nxt = ST_FULL;
            default: w_state_nxt = ST_LOAD;
        endcase
        if (i_clear) w_state_nxt = ST_LOAD;
    end

    // Clear only rewinds the pointer; a write already on the outputs has been issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
            r_we    <= 1'b0;
            r_addr  <= base_addr;
            r_wdata <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_clear) begin
                r_we    <= 1'b0;
                r_addr  <= base_addr;
                r_count <= '0;
            end else if (w_commit) begin
                r_we    <= 1'b1;
                r_addr  <= base_addr + (address_width'(r_count) << 2);
                r_wdata <= w_word;
                r_count <= r_count + 1'b1;
            end else begin
                r_we    <= 1'b0;
            end
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst || i_clear) r_err <= 1'b0;
        else if (w_accept && !w_range_ok) r_err <= 1'b1;
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_count     = r_count;
    assign o_full      = (r_state == ST_FULL);

endmodule
